// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and defaults shared by the UART receive and transmit sides
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: loadable down-counter that parks at zero and flags it
module uart_bit_timer #(
  parameter int CNT_W = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  assign zero = (cnt == '0);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver with mid-bit sampling, valid/ready output and error pulses
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int CNT_W        = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  uart_state_t          state;
  logic                 rx_meta, rx_s, rx_prev, armed;
  logic [1:0]           warm;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 zero, load, fall, done, hs;
  logic [CNT_W-1:0]     load_val;
  always_comb begin
    fall     = armed & rx_prev & ~rx_s;
    load     = (state == IDLE) ? fall : zero;
    load_val = (state == IDLE) ? CNT_W'(CLKS_PER_BIT / 2 - 1) : CNT_W'(CLKS_PER_BIT - 1);
    done     = (state == STOP) & zero & rx_s;
    hs       = rx_valid & rx_ready;
  end
  assign busy = (state != IDLE);
  uart_bit_timer #(.CNT_W(CNT_W)) u_timer (
    .clock(clock), .reset(reset), .load(load), .load_val(load_val), .zero(zero)
  );
  // The synchroniser resets high, so arm edge detection only once a real high level has propagated
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      warm    <= '0;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      warm    <= {warm[0], 1'b1};
      armed   <= armed | (warm[1] & rx_s);
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= (state == STOP) & zero & ~rx_s;
      overrun   <= done & rx_valid & ~hs;
      if (done & (~rx_valid | hs)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (hs) rx_valid <= 1'b0;
      case (state)
        IDLE:  if (fall) state <= START;
        START: if (zero) begin
          state   <= rx_s ? IDLE : DATA;
          bit_idx <= '0;
        end
        DATA:  if (zero) begin
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == IDX_W'(DATA_BITS - 1)) state <= STOP;
        end
        STOP:  if (zero) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: randomized scoreboard bench for the UART receiver
module tb_uart_rx_sampler;
  localparam int CPB = 16;
  logic       clock = 1'b0, reset = 1'b1, rx = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
  int         checks = 0, errors = 0;
  int         exp_fe = 0, exp_ovr = 0, got_fe = 0, got_ovr = 0;
  bit         pending = 1'b0;
  logic       prev_fe = 1'b0, prev_ovr = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_sampler #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .CNT_W(15)) dut (
    .clock(clock), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a good frame is delivered unless an undelivered byte is still waiting
  task automatic model_frame(input logic [7:0] b, input bit stop);
    if (!stop) exp_fe++;
    else if (!rx_ready && pending) exp_ovr++;
    else begin
      exp_q.push_back(b);
      pending = !rx_ready;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    model_frame(b, stop);
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clock);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || busy); i++) @(negedge clock);
    repeat (4) @(negedge clock);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    chk({tag, "_frame_err_count"}, got_fe, exp_fe);
    chk({tag, "_overrun_count"}, got_ovr, exp_ovr);
  endtask

  initial forever begin
    @(negedge clock);
    #1;
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte got %02h expected none", rx_data);
        end else chk("rx_data", rx_data, exp_q.pop_front());
      end
      if (frame_err) begin
        got_fe++;
        chk("frame_err_pulse_width", prev_fe, 0);
      end
      if (overrun) begin
        got_ovr++;
        chk("overrun_pulse_width", prev_ovr, 0);
      end
    end
    prev_fe  = frame_err;
    prev_ovr = overrun;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] f;
    logic [7:0] b;
    bit         s;
    repeat (3) @(negedge clock);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    idle(10);
    send_frame(8'hA5, 1'b1);
    idle(CPB);
    drain("t1");
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(CPB);
    drain("t2");
    send_frame(8'h3C, 1'b0);
    idle(2 * CPB);
    send_frame(8'h5A, 1'b1);
    idle(CPB);
    drain("t3");
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (2) @(negedge clock);
    chk("glitch_busy_high", busy, 1);
    repeat (2 * CPB) @(negedge clock);
    chk("glitch_busy_low", busy, 0);
    drain("t4");
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(CPB);
    chk("t5_valid_held", rx_valid, 1);
    chk("t5_data_held", rx_data, 8'h11);
    chk("t5_overrun_seen", got_ovr, exp_ovr);
    rx_ready = 1'b1;
    pending = 1'b0;
    repeat (3) @(negedge clock);
    chk("t5_valid_cleared", rx_valid, 0);
    drain("t5");
    f = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 4; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clock);
    end
    rx = f[4];
    repeat (CPB / 2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midreset_rx_valid", rx_valid, 0);
    chk("midreset_rx_data", rx_data, 0);
    chk("midreset_frame_err", frame_err, 0);
    chk("midreset_overrun", overrun, 0);
    chk("midreset_busy", busy, 0);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle(10);
    send_frame(8'h81, 1'b1);
    idle(CPB);
    drain("t6");
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 4) != 0);
      send_frame(b, s);
      if (!s) idle(CPB + int'($urandom_range(0, 8)));
      else idle(int'($urandom_range(0, 20)));
    end
    idle(CPB);
    drain("random");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
